// File: rtl/neuron_layer_sched_if.sv
// rtl/neuron_layer_sched_if.sv - input-vector and result-stream handshakes of the layer scheduler
// The master side is the producer of activation vectors and consumer of layer results.
interface neuron_layer_sched_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_a_1;
  logic signed [WIDTH-1:0] in_a_2;
  logic signed [WIDTH-1:0] in_a_3;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;

  modport master (
    output in_valid, in_a_1, in_a_2, in_a_3, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_a_1, in_a_2, in_a_3, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/neuron_layer_sched.sv
// rtl/neuron_layer_sched.sv - time-multiplexes one shared 3-input neuron across a layer
// Outputs are registered or decoded from state/idx only; no input reaches an output combinationally.
module neuron_layer_sched #(
  parameter int WIDTH       = 32,
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  neuron_layer_sched_if.slave     bus,
  output logic                    wb_rd_en,
  output logic [IDX_W-1:0]        wb_addr,
  input  logic signed [WIDTH-1:0] wb_w_1,
  input  logic signed [WIDTH-1:0] wb_w_2,
  input  logic signed [WIDTH-1:0] wb_w_3,
  input  logic signed [WIDTH-1:0] wb_b_1,
  input  logic signed [WIDTH-1:0] wb_b_2,
  input  logic signed [WIDTH-1:0] wb_b_3,
  output logic signed [WIDTH-1:0] n_a_1,
  output logic signed [WIDTH-1:0] n_a_2,
  output logic signed [WIDTH-1:0] n_a_3,
  output logic signed [WIDTH-1:0] n_w_1,
  output logic signed [WIDTH-1:0] n_w_2,
  output logic signed [WIDTH-1:0] n_w_3,
  output logic signed [WIDTH-1:0] n_b_1,
  output logic signed [WIDTH-1:0] n_b_2,
  output logic signed [WIDTH-1:0] n_b_3,
  input  logic signed [WIDTH-1:0] n_y,
  output logic                    busy
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  logic [2:0]              r_state;
  logic [IDX_W-1:0]        r_idx;
  logic signed [WIDTH-1:0] r_a_1, r_a_2, r_a_3;
  logic signed [WIDTH-1:0] r_w_1, r_w_2, r_w_3;
  logic signed [WIDTH-1:0] r_b_1, r_b_2, r_b_3;
  logic signed [WIDTH-1:0] r_out_data;
  logic [IDX_W-1:0]        r_out_idx;
  logic                    w_accept;
  logic                    w_last;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_last   = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_idx   <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD:  r_state <= S_EVAL;
        S_EVAL:  r_state <= S_EMIT;
        S_EMIT: begin
          // idx stays on the last neuron after the layer; it is cleared on the next accept
          if (bus.out_ready) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_1      <= '0;
      r_a_2      <= '0;
      r_a_3      <= '0;
      r_w_1      <= '0;
      r_w_2      <= '0;
      r_w_3      <= '0;
      r_b_1      <= '0;
      r_b_2      <= '0;
      r_b_3      <= '0;
      r_out_data <= '0;
      r_out_idx  <= '0;
    end else begin
      if (w_accept) begin
        r_a_1 <= bus.in_a_1;
        r_a_2 <= bus.in_a_2;
        r_a_3 <= bus.in_a_3;
      end
      // parameter memory has one cycle of read latency, so LOAD sees the FETCH address's data
      if (r_state == S_LOAD) begin
        r_w_1 <= wb_w_1;
        r_w_2 <= wb_w_2;
        r_w_3 <= wb_w_3;
        r_b_1 <= wb_b_1;
        r_b_2 <= wb_b_2;
        r_b_3 <= wb_b_3;
      end
      if (r_state == S_EVAL) begin
        r_out_data <= n_y;
        r_out_idx  <= r_idx;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_EMIT);
  assign bus.out_data  = r_out_data;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_last  = (r_state == S_EMIT) && w_last;
  assign wb_rd_en      = (r_state == S_FETCH);
  assign wb_addr       = r_idx;
  assign busy          = (r_state != S_IDLE);
  assign n_a_1 = r_a_1;
  assign n_a_2 = r_a_2;
  assign n_a_3 = r_a_3;
  assign n_w_1 = r_w_1;
  assign n_w_2 = r_w_2;
  assign n_w_3 = r_w_3;
  assign n_b_1 = r_b_1;
  assign n_b_2 = r_b_2;
  assign n_b_3 = r_b_3;
endmodule

// File: tb/tb_neuron_layer_sched.sv
// tb/tb_neuron_layer_sched.sv - scoreboard bench for neuron_layer_sched (4-neuron and 1-neuron builds)
// The bench plays the parameter memory and the shared neuron; expected results are queued on accept.
module tb_neuron_layer_sched;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int idx; int data; bit last; } exp_t;
  exp_t sb[$];

  function automatic int neuron_c_model(input int a1, a2, a3, w1, w2, w3, b1, b2, b3);
    int s;
    s = a1 * w1 + a2 * w2 + a3 * w3 + b1 + b2 + b3 + 64;
    if (s < 0) return 0;
    if (s > 128) return 128;
    return s;
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 4-neuron instance
  neuron_layer_sched_if #(.WIDTH(32), .IDX_W(2)) bus ();
  logic              wb_rd_en, busy;
  logic [1:0]        wb_addr;
  logic signed [31:0] wb_w_1, wb_w_2, wb_w_3, wb_b_1, wb_b_2, wb_b_3;
  logic signed [31:0] n_a_1, n_a_2, n_a_3, n_w_1, n_w_2, n_w_3, n_b_1, n_b_2, n_b_3, n_y;

  neuron_layer_sched #(.WIDTH(32), .NUM_NEURONS(4), .IDX_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .wb_rd_en(wb_rd_en), .wb_addr(wb_addr),
    .wb_w_1(wb_w_1), .wb_w_2(wb_w_2), .wb_w_3(wb_w_3),
    .wb_b_1(wb_b_1), .wb_b_2(wb_b_2), .wb_b_3(wb_b_3),
    .n_a_1(n_a_1), .n_a_2(n_a_2), .n_a_3(n_a_3),
    .n_w_1(n_w_1), .n_w_2(n_w_2), .n_w_3(n_w_3),
    .n_b_1(n_b_1), .n_b_2(n_b_2), .n_b_3(n_b_3),
    .n_y(n_y), .busy(busy)
  );

  always @(posedge clk) if (wb_rd_en) begin
    wb_w_1 <= 32'(wb_addr); wb_w_2 <= 32'(wb_addr); wb_w_3 <= 32'(wb_addr);
    wb_b_1 <= 0; wb_b_2 <= 0; wb_b_3 <= 0;
  end
  assign n_y = neuron_c_model(n_a_1, n_a_2, n_a_3, n_w_1, n_w_2, n_w_3, n_b_1, n_b_2, n_b_3);

  // 1-neuron instance
  neuron_layer_sched_if #(.WIDTH(32), .IDX_W(1)) bus1 ();
  logic              wb_rd_en1, busy1;
  logic [0:0]        wb_addr1;
  logic signed [31:0] wb1_w_1, wb1_w_2, wb1_w_3, wb1_b_1, wb1_b_2, wb1_b_3;
  logic signed [31:0] n1_a_1, n1_a_2, n1_a_3, n1_w_1, n1_w_2, n1_w_3, n1_b_1, n1_b_2, n1_b_3, n1_y;

  neuron_layer_sched #(.WIDTH(32), .NUM_NEURONS(1), .IDX_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .wb_rd_en(wb_rd_en1), .wb_addr(wb_addr1),
    .wb_w_1(wb1_w_1), .wb_w_2(wb1_w_2), .wb_w_3(wb1_w_3),
    .wb_b_1(wb1_b_1), .wb_b_2(wb1_b_2), .wb_b_3(wb1_b_3),
    .n_a_1(n1_a_1), .n_a_2(n1_a_2), .n_a_3(n1_a_3),
    .n_w_1(n1_w_1), .n_w_2(n1_w_2), .n_w_3(n1_w_3),
    .n_b_1(n1_b_1), .n_b_2(n1_b_2), .n_b_3(n1_b_3),
    .n_y(n1_y), .busy(busy1)
  );

  always @(posedge clk) if (wb_rd_en1) begin
    wb1_w_1 <= 32'(wb_addr1) + 2; wb1_w_2 <= 32'(wb_addr1) + 2; wb1_w_3 <= 32'(wb_addr1) + 2;
    wb1_b_1 <= 0; wb1_b_2 <= 0; wb1_b_3 <= 0;
  end
  assign n1_y = neuron_c_model(n1_a_1, n1_a_2, n1_a_3, n1_w_1, n1_w_2, n1_w_3, n1_b_1, n1_b_2, n1_b_3);

  // monitor: queue expectations on accept, compare on result handshake, check timing
  int acc_cyc, hs_cyc;
  bit expect_first = 0, pend_gap = 0, held_pend = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      expect_first = 0; pend_gap = 0; held_pend = 0;
    end else begin
      if (bus.in_valid && busy) chk("in_ready_busy", bus.in_ready, 0);
      if (bus.in_valid && bus.in_ready) begin
        if (held_pend) chk("accept_after_last", cyc - hs_cyc, 1);
        held_pend = 0;
        acc_cyc = cyc;
        expect_first = 1;
        for (int k = 0; k < 4; k++)
          sb.push_back('{k, neuron_c_model(bus.in_a_1, bus.in_a_2, bus.in_a_3, k, k, k, 0, 0, 0), k == 3});
      end
      if (bus.out_valid) begin
        if (expect_first) chk("first_latency", cyc - acc_cyc, 4);
        else if (pend_gap) chk("result_gap", cyc - hs_cyc, 4);
        expect_first = 0;
        pend_gap = 0;
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_result_idx", bus.out_idx, -1);
          end else begin
            e = sb.pop_front();
            chk("out_idx", bus.out_idx, e.idx);
            chk("out_data", bus.out_data, e.data);
            chk("out_last", bus.out_last, e.last);
          end
          hs_cyc = cyc;
          if (bus.out_last) held_pend = bus.in_valid;
          else pend_gap = 1;
        end
      end
    end
  end

  task automatic present(input int a1, a2, a3);
    bus.in_valid = 1'b1; bus.in_a_1 = a1; bus.in_a_2 = a2; bus.in_a_3 = a3;
  endtask

  task automatic wait_accept();
    int i;
    for (i = 0; i < 200; i++) begin
      if (bus.in_ready) break;
      @(posedge clk); #1;
    end
    chk("accept_timeout", i, (i < 200) ? i : 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_rd(input int addr, input bit match_addr);
    int i;
    for (i = 0; i < 200; i++) begin
      if (wb_rd_en && (!match_addr || wb_addr == addr)) break;
      @(posedge clk); #1;
    end
    chk("rd_timeout", i, (i < 200) ? i : 0);
  endtask

  task automatic wait_ov();
    int i;
    for (i = 0; i < 200; i++) begin
      if (bus.out_valid) break;
      @(posedge clk); #1;
    end
    chk("ov_timeout", i, (i < 200) ? i : 0);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("idle_timeout", i, (i < 400) ? i : 0);
  endtask

  initial begin
    int held;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_a_1 = 0; bus.in_a_2 = 0; bus.in_a_3 = 0; bus.out_ready = 1;
    bus1.in_valid = 0; bus1.in_a_1 = 0; bus1.in_a_2 = 0; bus1.in_a_3 = 0; bus1.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_rd_en", wb_rd_en, 0);
    chk("rst_n_a_1", n_a_1, 0);
    chk("rst_n_w_2", n_w_2, 0);
    chk("rst_out_data", bus.out_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // layer 1 with a stall on idx 1; next vector held valid throughout
    present(1, 2, 3);
    wait_accept();
    present(4, 5, 6);
    wait_rd(1, 1'b1);
    chk("stall_fetch_addr", wb_addr, 1);
    bus.out_ready = 1'b0;
    wait_ov();
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_idx", bus.out_idx, 1);
      chk("stall_data", bus.out_data, held);
      chk("stall_rd", wb_rd_en, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    wait_rd(0, 1'b0);
    chk("release_fetch_addr", wb_addr, 2);
    wait_accept();
    chk("vec2_n_a_1", n_a_1, 4);
    chk("vec2_n_a_2", n_a_2, 5);
    chk("vec2_n_a_3", n_a_3, 6);
    wait_rd(0, 1'b0);
    chk("vec2_first_addr", wb_addr, 0);
    wait_idle();

    // reset during EVAL of idx 2
    present(7, 8, 9);
    wait_accept();
    wait_rd(2, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wb_rd_en", wb_rd_en, 0);
    chk("mid_rst_wb_addr", wb_addr, 0);
    chk("mid_rst_n_a_1", n_a_1, 0);
    chk("mid_rst_n_w_1", n_w_1, 0);
    chk("mid_rst_n_b_3", n_b_3, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_out_idx", bus.out_idx, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_valid", bus.out_valid, 0);
      @(posedge clk); #1;
    end
    present(2, -1, 3);
    wait_accept();
    wait_rd(0, 1'b0);
    chk("post_rst_first_addr", wb_addr, 0);
    wait_idle();

    // single-neuron build
    bus1.in_valid = 1'b1; bus1.in_a_1 = 1; bus1.in_a_2 = 2; bus1.in_a_3 = 3;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    begin
      int i;
      for (i = 0; i < 50; i++) begin
        if (bus1.out_valid) break;
        @(posedge clk); #1;
      end
      chk("n1_ov_timeout", i, (i < 50) ? i : 0);
    end
    chk("n1_out_idx", bus1.out_idx, 0);
    chk("n1_out_last", bus1.out_last, 1);
    chk("n1_out_data", bus1.out_data, neuron_c_model(1, 2, 3, 2, 2, 2, 0, 0, 0));
    @(posedge clk); #1;
    chk("n1_idle_in_ready", bus1.in_ready, 1);
    chk("n1_idle_busy", busy1, 0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
